// File: rtl/state_frame_tx.sv
// state_frame_tx: returns the 16-bit unit state plus a 4-bit sequence number as an async serial frame.
// Define STATE_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module state_frame_tx #(
  parameter int CLK_DIV  = 50,
  parameter int GAP_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic        fault,
  input  logic [15:0] state,
  output logic        txd,
  output logic        busy,
  output logic        done,
  output logic [3:0]  seq
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int IW = ($clog2(GAP_BITS + 1) > 5) ? $clog2(GAP_BITS + 1) : 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_GAP
  } fsm_t;

  fsm_t          fsm_q, fsm_n;
  logic [TW-1:0] timer_q, timer_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [19:0]   shreg_q, shreg_n;
  logic [3:0]    seq_q, seq_n;
  logic          pending_q, pending_n;
  logic          fault_d;
  logic          txd_q, txd_n;
  logic          req;
  logic          bit_end;
  logic          gap_last;
  logic          start_frame;

  assign req      = send | (fault & ~fault_d);
  assign bit_end  = (timer_q == TW'(CLK_DIV - 1));
  assign gap_last = (idx_q == IW'(GAP_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      seq_q     <= '0;
      pending_q <= 1'b0;
      fault_d   <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      fsm_q     <= fsm_n;
      timer_q   <= timer_n;
      idx_q     <= idx_n;
      shreg_q   <= shreg_n;
      seq_q     <= seq_n;
      pending_q <= pending_n;
      fault_d   <= fault;
      txd_q     <= txd_n;
    end
  end

  always_comb begin
    fsm_n       = fsm_q;
    timer_n     = timer_q;
    idx_n       = idx_q;
    shreg_n     = shreg_q;
    seq_n       = seq_q;
    pending_n   = pending_q;
    start_frame = 1'b0;
    txd_n       = 1'b1;

    if (fsm_q != S_IDLE) begin
      timer_n = bit_end ? '0 : timer_q + 1'b1;
      if (req) pending_n = 1'b1;
    end

    // idx counts data bits in DATA and gap bit-times in GAP
    case (fsm_q)
      S_IDLE:  if (req) start_frame = 1'b1;
      S_START: if (bit_end) begin
        fsm_n = S_DATA;
        idx_n = '0;
      end
      S_DATA:  if (bit_end) begin
        if (idx_q == IW'(19)) begin
`ifdef STATE_TX_PARITY_EN
          fsm_n = S_PAR;
`else
          fsm_n = S_STOP;
`endif
        end else begin
          idx_n = idx_q + 1'b1;
        end
      end
      S_PAR:   if (bit_end) fsm_n = S_STOP;
      S_STOP:  if (bit_end) begin
        fsm_n = S_GAP;
        idx_n = '0;
      end
      S_GAP:   if (bit_end) begin
        if (gap_last) begin
          if (pending_q || req) start_frame = 1'b1;
          else                  fsm_n = S_IDLE;
        end else begin
          idx_n = idx_q + 1'b1;
        end
      end
      default: fsm_n = S_IDLE;
    endcase

    // Frame start latches state and the incremented seq together; pending is consumed here
    if (start_frame) begin
      fsm_n     = S_START;
      timer_n   = '0;
      idx_n     = '0;
      seq_n     = seq_q + 4'd1;
      shreg_n   = {seq_q + 4'd1, state};
      pending_n = 1'b0;
    end

    case (fsm_n)
      S_START: txd_n = 1'b0;
      S_DATA:  txd_n = shreg_n[idx_n[4:0]];
      S_PAR:   txd_n = ^shreg_n;
      default: txd_n = 1'b1;
    endcase
  end

  assign txd  = txd_q;
  assign busy = (fsm_q != S_IDLE);
  assign done = (fsm_q == S_GAP) && bit_end && gap_last;
  assign seq  = seq_q;

endmodule

// File: tb/tb_state_frame_tx.sv
// Directed bench for state_frame_tx with CLK_DIV=4, GAP_BITS=2; follows STATE_TX_PARITY_EN if defined.
module tb_state_frame_tx;

  localparam int CLK_DIV  = 4;
  localparam int GAP_BITS = 2;
`ifdef STATE_TX_PARITY_EN
  localparam int NB      = 23;
  localparam int T1_DONE = 110;
`else
  localparam int NB      = 22;
  localparam int T1_DONE = 106;
`endif
  localparam int FRAME_CYC = NB * CLK_DIV;
  localparam int GAP_CYC   = GAP_BITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        send;
  logic        fault;
  logic [15:0] state;
  logic        txd;
  logic        busy;
  logic        done;
  logic [3:0]  seq;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] bits;
    int          start;
    int          done_at;
    int          ndone;
    int          bad;
  } frame_t;

  typedef struct {
    logic [15:0] st;
    logic [3:0]  exp_seq;
  } vec_t;

  state_frame_tx #(.CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .send  (send),
    .fault (fault),
    .state (state),
    .txd   (txd),
    .busy  (busy),
    .done  (done),
    .seq   (seq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bit i of the result is the i-th bit on the line: start, 16 state bits, 4 seq bits, [parity], stop
  function automatic logic [31:0] exp_frame(input logic [15:0] st, input logic [3:0] sq);
    logic [31:0] f;
    f = '0;
    f[16:1]  = st;
    f[20:17] = sq;
`ifdef STATE_TX_PARITY_EN
    f[21] = ^{sq, st};
`endif
    f[NB-1] = 1'b1;
    return f;
  endfunction

  task automatic pulse_send();
    @(posedge clk); #1 send = 1'b1;
    @(posedge clk); #1 send = 1'b0;
  endtask

  // Waits for a start bit, then records one frame plus its gap; returns on the last gap cycle
  task automatic grab_frame(output frame_t f);
    int w;
    w = 0;
    f.bits = '0; f.start = -1; f.done_at = -1; f.ndone = 0; f.bad = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(busy === 1'b1 && txd === 1'b0) && w < 300);
    if (!(busy === 1'b1 && txd === 1'b0)) begin
      f.bad = 999;
      return;
    end
    f.start = cyc;
    for (int c = 0; c < FRAME_CYC + GAP_CYC; c++) begin
      if (c > 0) @(negedge clk);
      if (c < FRAME_CYC) begin
        if (c % CLK_DIV == 0) f.bits[c / CLK_DIV] = txd;
        else if (txd !== f.bits[c / CLK_DIV]) f.bad++;
      end else if (txd !== 1'b1) begin
        f.bad++;
      end
      if (busy !== 1'b1) f.bad++;
      if (done === 1'b1) begin
        f.ndone++;
        f.done_at = cyc;
      end
    end
  endtask

  task automatic check_frame(input string nm, input frame_t f, input logic [15:0] st,
                             input logic [3:0] sq);
    check({nm, "_bits"}, f.bits, exp_frame(st, sq));
    check({nm, "_stable"}, f.bad, 0);
    check({nm, "_ndone"}, f.ndone, 1);
    check({nm, "_done_cyc"}, f.done_at, f.start + FRAME_CYC + GAP_CYC - 1);
    check({nm, "_seq_out"}, seq, sq);
  endtask

  vec_t   tbl[5];
  frame_t f, fa, fb;
  int     nb;
  int     prev_end;
  logic [3:0]  es;
  logic [15:0] est;

  initial begin
    tbl[0] = '{st: 16'h0001, exp_seq: 4'd2};
    tbl[1] = '{st: 16'hFFFF, exp_seq: 4'd3};
    tbl[2] = '{st: 16'h0000, exp_seq: 4'd4};
    tbl[3] = '{st: 16'h8000, exp_seq: 4'd5};
    tbl[4] = '{st: 16'h1234, exp_seq: 4'd6};

    rst = 1'b1; send = 1'b0; fault = 1'b0; state = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_seq", seq, 4'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Request in cycle 10; state changes after latch must be ignored
    while (cyc != 10) begin
      @(posedge clk); #1;
    end
    state = 16'hA5C3;
    send  = 1'b1;
    @(posedge clk); #1 send = 1'b0;
    state = 16'hFFFF;
    grab_frame(f);
    check("t1_start_cyc", f.start, 11);
    check("t1_state_bits", f.bits[16:1], 16'hA5C3);
    check("t1_seq_bits", f.bits[20:17], 4'b0001);
    check("t1_done_abs", f.done_at, T1_DONE);
    check_frame("t1", f, 16'hA5C3, 4'd1);
    @(negedge clk);
    check("t1_busy_low", busy, 1'b0);
    check("t1_txd_idle", txd, 1'b1);

    for (int i = 0; i < 5; i++) begin
      state = tbl[i].st;
      pulse_send();
      state = ~tbl[i].st;
      grab_frame(f);
      check_frame($sformatf("tbl%0d", i), f, tbl[i].st, tbl[i].exp_seq);
      @(negedge clk);
      check($sformatf("tbl%0d_idle", i), busy, 1'b0);
    end

    // Three sends during one frame coalesce into one follow-up frame
    state = 16'h3C3C;
    pulse_send();
    fork
      grab_frame(fa);
      begin
        repeat (10) @(posedge clk);
        #1 send = 1'b1;
        @(posedge clk); #1 send = 1'b0; state = 16'h0F0F;
        repeat (15) @(posedge clk);
        #1 send = 1'b1;
        @(posedge clk); #1 send = 1'b0;
        repeat (15) @(posedge clk);
        #1 send = 1'b1;
        @(posedge clk); #1 send = 1'b0;
      end
    join
    check_frame("t3a", fa, 16'h3C3C, 4'd7);
    grab_frame(fb);
    check("t3_followup_start", fb.start, fa.done_at + 1);
    check_frame("t3b", fb, 16'h0F0F, 4'd8);
    nb = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy !== 1'b0) nb++;
    end
    check("t3_no_third_frame", nb, 0);

    // Fault rising edge, held high: one frame; fall then rise: another
    @(posedge clk); #1 fault = 1'b1; state = 16'h00F0;
    grab_frame(f);
    check_frame("t4a", f, 16'h00F0, 4'd9);
    nb = 0;
    repeat (400) begin
      @(negedge clk);
      if (busy !== 1'b0) nb++;
    end
    check("t4_held_one_frame", nb, 0);
    @(posedge clk); #1 fault = 1'b0;
    repeat (5) @(posedge clk);
    #1 fault = 1'b1; state = 16'h0F00;
    grab_frame(f);
    check_frame("t4b", f, 16'h0F00, 4'd10);
    @(posedge clk); #1 fault = 1'b0;
    repeat (5) @(posedge clk);

    // Send and fault edge in the same cycle: one frame
    #1 send = 1'b1; fault = 1'b1; state = 16'hC001;
    @(posedge clk); #1 send = 1'b0;
    grab_frame(f);
    check_frame("simul", f, 16'hC001, 4'd11);
    nb = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0) nb++;
    end
    check("simul_one_frame", nb, 0);
    @(posedge clk); #1 fault = 1'b0;

    // Reset during data bit 7 with a pending request outstanding
    state = 16'hBEEF;
    pulse_send();
    repeat (5) @(posedge clk);
    #1 send = 1'b1;
    @(posedge clk); #1 send = 1'b0;
    repeat (27) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_txd", txd, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_seq", seq, 4'd0);
    check("t6_done", done, 1'b0);
    nb = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0) nb++;
    end
    check("t6_pending_cleared", nb, 0);
    state = 16'h0001;
    pulse_send();
    grab_frame(f);
    check_frame("t6_after", f, 16'h0001, 4'd1);

    // 16 back-to-back frames via pending; seq wraps to 0 on the last
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    state = 16'h1000;
    pulse_send();
    prev_end = 0;
    for (int k = 0; k < 16; k++) begin
      es  = 4'(k + 1);
      est = 16'h1000 + 16'(k);
      fork
        grab_frame(f);
        begin
          if (k < 15) begin
            repeat (10) @(posedge clk);
            #1 send = 1'b1; state = 16'h1000 + 16'(k + 1);
            @(posedge clk); #1 send = 1'b0;
          end
        end
      join
      check_frame($sformatf("b2b%0d", k), f, est, es);
      if (k > 0) check($sformatf("b2b%0d_contig", k), f.start, prev_end + 1);
      prev_end = f.done_at;
    end
    check("wrap_seq", seq, 4'd0);
    @(negedge clk);
    check("wrap_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
